// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and parity helper
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity bit a transmitter would send for this byte.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - serial input and received-byte/status bundle of the RX core
interface uart_rx_core_if;
    import uart_pkg::*;

    logic              rx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              par_err;
    logic              frame_err;
    logic              rx_busy;

    // The receiver core: reads the line, drives byte and status.
    modport master (
        input  rx,
        output rx_data, rx_valid, par_err, frame_err, rx_busy
    );

    // The line driver and byte consumer (FIFO / register block).
    modport slave (
        output rx,
        input  rx_data, rx_valid, par_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; reset value chosen to match the line's idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: start qualify, mid-bit sampling, parity and stop check
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.master bus
);
    import uart_pkg::*;

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(DATA_W - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    logic              rx_s;
    logic              rx_d;
    logic [2:0]        state;
    logic [CNT_W-1:0]  clk_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              par_mismatch;
    logic              cnt_full;
    logic              cnt_half;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    // Delayed copy of the synchronised line; a start needs a real high-to-low edge.
    always_ff @(posedge clk) begin
        if (rst) rx_d <= 1'b1;
        else     rx_d <= rx_s;
    end

    assign cnt_full    = (clk_cnt == FULL_M1);
    assign cnt_half    = (clk_cnt == HALF_M1);
    assign bus.rx_busy = (state != IDLE);

    // Frame state machine; outputs are registered and pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            par_mismatch  <= 1'b0;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.par_err   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.rx_valid  <= 1'b0;
            bus.par_err   <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s && rx_d) begin
                        state        <= START;
                        par_mismatch <= 1'b0;
                    end
                end
                START: begin
                    // Half a bit in: still low means a genuine start bit.
                    if (cnt_half) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_full) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == BIT_LAST) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_full) begin
                        clk_cnt      <= '0;
                        par_mismatch <= (rx_s != calc_parity(shift_reg, ODD));
                        state        <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch the next start edge.
                    if (cnt_full) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
                            bus.rx_data  <= shift_reg;
                            bus.rx_valid <= 1'b1;
                            bus.par_err  <= par_mismatch;
                        end else begin
                            bus.frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core without and with parity
module tb_uart_rx_core;

    localparam int CPB = 16;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_core_if bus0 ();
    uart_rx_core_if bus1 ();

    uart_rx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    uart_rx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   vcyc0[$];
    logic [7:0] prev0 = 8'h00;
    logic [7:0] prev1 = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input bit ferr, input logic [7:0] data, input bit perr);
        exp_t e;
        e.ferr = ferr;
        e.data = data;
        e.perr = perr;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic v, input logic fe, input logic pe,
                       input logic [7:0] dat);
        exp_t e;
        int   sz;
        if (v || fe) begin
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output dut%0d valid=%0b ferr=%0b data=%0h expected nothing",
                         d, v, fe, dat);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d_kind", d), {30'd0, v, fe}, e.ferr ? 32'd1 : 32'd2);
                chk($sformatf("dut%0d_data", d), {24'd0, dat}, {24'd0, e.data});
                chk($sformatf("dut%0d_par_err", d), {31'd0, pe}, {31'd0, e.perr});
            end
        end
    endtask

    // Output monitor for both receivers, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev0 <= bus0.rx_data;
            prev1 <= bus1.rx_data;
        end else begin
            mon(0, bus0.rx_valid, bus0.frame_err, bus0.par_err, bus0.rx_data);
            mon(1, bus1.rx_valid, bus1.frame_err, bus1.par_err, bus1.rx_data);
            if (bus0.rx_valid) vcyc0.push_back(cyc);
            if (bus0.rx_data !== prev0) chk("dut0_data_change_on_valid", {31'd0, bus0.rx_valid}, 32'd1);
            if (bus1.rx_data !== prev1) chk("dut1_data_change_on_valid", {31'd0, bus1.rx_valid}, 32'd1);
            prev0 <= bus0.rx_data;
            prev1 <= bus1.rx_data;
        end
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) bus0.rx = v;
        else        bus1.rx = v;
    endtask

    // Called at posedge+1; returns at posedge+1, so frames chain with no gap.
    task automatic hold_bit(input int d, input logic v);
        set_rx(d, v);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int d, input logic [7:0] b, input bit stop,
                              input bit has_par, input bit par);
        hold_bit(d, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d, b[i]);
        if (has_par) hold_bit(d, par);
        hold_bit(d, stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d, input int limit);
        int n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("dut%0d_drain_pending", d), (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        bus0.rx = 1'b1;
        bus1.rx = 1'b1;
        rst     = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {31'd0, bus0.rx_valid}, 0);
        chk("reset_data", {24'd0, bus0.rx_data}, 0);
        chk("reset_ferr", {31'd0, bus0.frame_err}, 0);
        chk("reset_busy", {31'd0, bus0.rx_busy}, 0);
        chk("reset_perr1", {31'd0, bus1.par_err}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // 1: single byte
        push(0, 0, 8'h55, 0);
        send_frame(0, 8'h55, 1, 0, 0);
        drain(0, 40);
        @(negedge clk);
        chk("t1_busy_after", {31'd0, bus0.rx_busy}, 0);
        @(posedge clk); #1;
        idle(5);

        // 2: back-to-back frames, pulses one frame apart
        vcyc0.delete();
        push(0, 0, 8'hA5, 0);
        push(0, 0, 8'h3C, 0);
        send_frame(0, 8'hA5, 1, 0, 0);
        send_frame(0, 8'h3C, 1, 0, 0);
        drain(0, 40);
        chk("t2_pulse_count", vcyc0.size(), 2);
        if (vcyc0.size() == 2) chk("t2_pulse_spacing", vcyc0[1] - vcyc0[0], 160);
        idle(5);

        // 3: glitch shorter than half a bit
        set_rx(0, 1'b0);
        idle(6);
        chk("t3_busy_during_glitch", {31'd0, bus0.rx_busy}, 1);
        set_rx(0, 1'b1);
        begin
            int k = 0;
            while (bus0.rx_busy && k < 8) begin
                @(posedge clk); #1;
                k++;
            end
            chk("t3_busy_clears", {31'd0, bus0.rx_busy}, 0);
        end
        idle(20);

        // 4: framing error keeps old data, then recovery
        push(0, 1, 8'h3C, 0);
        send_frame(0, 8'h81, 0, 0, 0);
        drain(0, 40);
        set_rx(0, 1'b1);
        idle(CPB);
        push(0, 0, 8'h12, 0);
        send_frame(0, 8'h12, 1, 0, 0);
        drain(0, 40);
        idle(5);

        // 5: even parity, wrong then right parity bit
        push(1, 0, 8'h07, 1);
        send_frame(1, 8'h07, 1, 1, 0);
        drain(1, 40);
        idle(5);
        push(1, 0, 8'h07, 0);
        send_frame(1, 8'h07, 1, 1, 1);
        drain(1, 40);
        idle(5);

        // 6: reset during data bit 4 aborts the frame
        fork
            send_frame(0, 8'hFF, 1, 0, 0);
            begin
                idle(CPB + 4 * CPB + CPB / 2);
                rst = 1'b1;
                idle(3);
                rst = 1'b0;
                @(negedge clk);
                chk("t6_busy_after_reset", {31'd0, bus0.rx_busy}, 0);
                chk("t6_data_after_reset", {24'd0, bus0.rx_data}, 0);
            end
        join
        idle(CPB);
        push(0, 0, 8'h42, 0);
        send_frame(0, 8'h42, 1, 0, 0);
        drain(0, 40);
        idle(3 * CPB);

        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycles=%0d limit=20000", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial-to-parallel UART receiver for the APB<->UART IP; the stage directly upstream of the RX FIFO.
- Synchronises the asynchronous rx line, detects and qualifies the start bit, samples 8 data bits LSB-first at mid-bit, plus optional parity and one stop bit.
- Delivers each good byte as a held data word with a 1-cycle valid strobe. rx_data feeds FIFO data_in; rx_valid feeds FIFO w_ready.
- Reports framing, parity and busy status to the APB register block.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- PARITY_EN, 0, 1 = a parity bit follows D7.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last received byte; held stable until the next good frame completes.
- rx_valid  out  1  1-cycle pulse: rx_data updated with a good (stop=1) frame.
- par_err  out  1  1-cycle pulse, coincident with rx_valid, when parity mismatched.
- frame_err  out  1  1-cycle pulse: stop bit sampled 0.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0. Synchroniser flops preset to 1. State = IDLE. Counters = 0.
- Input sync: 2-flop synchroniser, then a third flop (rx_d) for edge detection. Start is detected on rx_s=0 and rx_d=1.
- Bit counter clk_cnt: width $clog2(CLKS_PER_BIT). Reloads to 0 on every state change and on every bit sample.
- IDLE: wait for the falling edge, then go to START with clk_cnt=0. A line that is already low does not trigger; a fresh high-to-low edge is required.
- START: at clk_cnt == CLKS_PER_BIT/2 - 1, re-sample rx_s.
  - If 1: false start; go to IDLE with no outputs.
  - If 0: go to DATA with bit_idx=0.
- DATA: every CLKS_PER_BIT clocks, sample rx_s into shift_reg[bit_idx]. Sampling is LSB first and lands at mid-bit. After bit_idx=7 go to PARITY if PARITY_EN, else STOP.
- PARITY: sample after CLKS_PER_BIT clocks. Expected parity = ^shift_reg XOR PARITY_ODD. Latch the mismatch flag, then go to STOP.
- STOP: sample after CLKS_PER_BIT clocks.
  - Sample 1: next clock rx_data <= shift_reg, rx_valid=1, par_err = latched mismatch. Return to IDLE.
  - Sample 0: next clock frame_err=1, rx_valid=0, rx_data unchanged. Return to IDLE. A held-low (break) line generates no further frames until it returns high and falls again.
- Latency: rx_valid asserts 3 clk after the stop-bit mid-sample point on the rx pin (2 sync + 1 register).
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving ≥0.5 bit later is caught. Full line rate is supported.
- rx_valid never asserts on consecutive cycles. Minimum spacing is one frame, which covers the downstream FIFO's edge detector.
- rx_data changes only on the rx_valid cycle. It stays stable ≥ 8 bit times for the downstream capture.
- Reset mid-frame: immediate return to IDLE with outputs 0. The partial byte is discarded. No rx_valid or error pulse for that frame.
- rx_busy=1 in START, DATA, PARITY and STOP.

Decomposition:
- Package uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP) and the DATA_W=8 constant, shared with the TX core.
- One natural sub-module, uart_sync2: 2-flop synchroniser with parameterised reset value, reused on the TX cts path.
- Everything else stays in uart_rx_core.

Test Plan:
1. CLKS_PER_BIT=16, PARITY_EN=0. Drive frame 0x55 (start, 1010_1010 LSB first, stop) -> one rx_valid pulse, rx_data=0x55, frame_err=0, rx_busy low after the pulse.
2. Back-to-back frames 0xA5, 0x3C with no idle gap -> two rx_valid pulses exactly 160 clk apart, with rx_data 0xA5 then 0x3C.
3. rx low for 6 clk, then high (glitch < half bit) -> no rx_valid, no frame_err, rx_busy returns low within 8 clk.
4. Frame 0x81 with stop bit forced 0 -> frame_err pulse, rx_valid=0, rx_data keeps its previous value. Then a valid 0x12 frame -> rx_valid, rx_data=0x12.
5. PARITY_EN=1, PARITY_ODD=0, byte 0x07 sent with parity bit 0 (wrong) -> rx_valid and par_err in the same cycle, rx_data=0x07. Repeat with parity bit 1 -> par_err=0.
6. Assert rst during data bit 4 of frame 0xFF, release it, then send 0x42 -> no output for the aborted frame, then a single rx_valid with rx_data=0x42.
